// File: rtl/uart_bus_bridge.sv
// UART command bridge: decodes W/R byte frames into single-word bus accesses and
// returns an acknowledge byte, a NAK byte or four read-data bytes over the UART.
module uart_bus_bridge #(
    parameter int unsigned READ_LAT       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0]  ACK_BYTE       = 8'h4B,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_done_tick,
    output logic [7:0]  tx_din,
    output logic        tx_start,
    input  logic        tx_done_tick,
    output logic [15:0] address,
    output logic [31:0] w_data,
    output logic        we,
    input  logic [31:0] r_data,
    output logic        busy
);

    localparam logic [7:0]      CMD_WRITE = 8'h57;
    localparam logic [7:0]      CMD_READ  = 8'h52;
    localparam int unsigned     TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      LAT_LAST  = 4'(READ_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StGetAddr,
        StGetData,
        StBusWrite,
        StBusRead,
        StTxByte,
        StTxWait
    } state_e;

    state_e          state_q, state_d;
    logic            is_write_q, is_write_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]      lat_cnt_q, lat_cnt_d;
    logic [15:0]     address_q, address_d;
    logic [31:0]     w_data_q, w_data_d;
    logic [7:0]      tx_din_q, tx_din_d;
    // Read bytes not yet on tx_din; the top byte goes straight to tx_din
    logic [23:0]     rd_shift_q, rd_shift_d;
    // Bytes still to send after the one currently on tx_din
    logic [1:0]      rem_q, rem_d;

    // Next-state and datapath decode for the frame/response sequencer
    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d   = to_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        address_d  = address_q;
        w_data_d   = w_data_q;
        tx_din_d   = tx_din_q;
        rd_shift_d = rd_shift_q;
        rem_d      = rem_q;

        case (state_q)
            StIdle: begin
                if (rx_done_tick) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        is_write_d = (rx_data == CMD_WRITE);
                        byte_cnt_d = 2'd0;
                        to_cnt_d   = '0;
                        state_d    = StGetAddr;
                    end else begin
                        tx_din_d = NAK_BYTE;
                        rem_d    = 2'd0;
                        state_d  = StTxByte;
                    end
                end
            end

            StGetAddr: begin
                if (rx_done_tick) begin
                    // A byte on the expiry cycle still counts and restarts the timer
                    address_d  = {address_q[7:0], rx_data};
                    to_cnt_d   = '0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd1) begin
                        byte_cnt_d = 2'd0;
                        lat_cnt_d  = 4'd0;
                        state_d    = is_write_q ? StGetData : StBusRead;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            StGetData: begin
                if (rx_done_tick) begin
                    w_data_d   = {w_data_q[23:0], rx_data};
                    to_cnt_d   = '0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        state_d    = StBusWrite;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            StBusWrite: begin
                tx_din_d = ACK_BYTE;
                rem_d    = 2'd0;
                state_d  = StTxByte;
            end

            StBusRead: begin
                if (lat_cnt_q == LAT_LAST) begin
                    tx_din_d   = r_data[31:24];
                    rd_shift_d = r_data[23:0];
                    rem_d      = 2'd3;
                    state_d    = StTxByte;
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end

            StTxByte: begin
                state_d = StTxWait;
            end

            StTxWait: begin
                if (tx_done_tick) begin
                    if (rem_q != 2'd0) begin
                        tx_din_d   = rd_shift_q[23:16];
                        rd_shift_d = {rd_shift_q[15:0], 8'h00};
                        rem_d      = rem_q - 2'd1;
                        state_d    = StTxByte;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            is_write_q <= 1'b0;
            byte_cnt_q <= 2'd0;
            to_cnt_q   <= '0;
            lat_cnt_q  <= 4'd0;
            address_q  <= 16'h0000;
            w_data_q   <= 32'h0000_0000;
            tx_din_q   <= 8'h00;
            rd_shift_q <= 24'h00_0000;
            rem_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            byte_cnt_q <= byte_cnt_d;
            to_cnt_q   <= to_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            address_q  <= address_d;
            w_data_q   <= w_data_d;
            tx_din_q   <= tx_din_d;
            rd_shift_q <= rd_shift_d;
            rem_q      <= rem_d;
        end
    end

    // Strobes decode directly from state so they can never outlive their state
    assign we       = (state_q == StBusWrite);
    assign tx_start = (state_q == StTxByte);
    assign busy     = (state_q != StIdle);
    assign address  = address_q;
    assign w_data   = w_data_q;
    assign tx_din   = tx_din_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench: two bridges (READ_LAT 1 and 3) share the rx byte stream; each has
// its own transmitter and bus model. Expected bus writes and tx bytes are derived from
// the frames sent and the documented latencies, and checked on every cycle.
module tb_uart_bus_bridge;

    localparam int unsigned TIMEOUT = 100;
    localparam int          N_INST  = 2;
    localparam logic [7:0]  ACK     = 8'h4B;
    localparam logic [7:0]  NAK     = 8'h15;
    localparam int          IDLE_BOUND = 80;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_ev_t;

    // cyc < 0 means: one cycle after the previous tx_done_tick
    typedef struct {
        logic [7:0] b;
        int         cyc;
    } tx_ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  tx_din [N_INST];
    logic        tx_start [N_INST];
    logic        tx_done_tick [N_INST];
    logic [15:0] address [N_INST];
    logic [31:0] w_data [N_INST];
    logic        we [N_INST];
    logic [31:0] r_data [N_INST];
    logic        busy [N_INST];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int last_t = 0;

    wr_ev_t     exp_wr [N_INST][$];
    tx_ev_t     exp_tx [N_INST][$];
    bit         tx_busy_m [N_INST];
    int         done_at [N_INST];
    int         last_done [N_INST];
    logic [7:0] tx_cur [N_INST];
    logic [15:0] m_addr = 16'h0000;
    logic [31:0] m_wdata = 32'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] bus_word(input logic [15:0] a);
        if (a == 16'h0020) return 32'h1234_5678;
        return {a ^ 16'h5A3C, ~a ^ 16'h00FF};
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < N_INST; g++) begin : g_inst
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        logic [15:0] a1, a2;

        uart_bus_bridge #(
            .READ_LAT      (LAT),
            .TIMEOUT_CYCLES(TIMEOUT),
            .ACK_BYTE      (ACK),
            .NAK_BYTE      (NAK)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .rx_data     (rx_data),
            .rx_done_tick(rx_done_tick),
            .tx_din      (tx_din[g]),
            .tx_start    (tx_start[g]),
            .tx_done_tick(tx_done_tick[g]),
            .address     (address[g]),
            .w_data      (w_data[g]),
            .we          (we[g]),
            .r_data      (r_data[g]),
            .busy        (busy[g])
        );

        // Bus with read latency: data reflects the address LAT-1 cycles earlier
        always @(posedge clk) begin
            a1 <= address[g];
            a2 <= a1;
        end
        assign r_data[g] = bus_word((LAT == 1) ? address[g] : a2);

        // Per-cycle compare and transmitter capture
        always begin
            @(negedge clk);
            if (we[g]) begin
                if (exp_wr[g].size() == 0) begin
                    chk($sformatf("i%0d_unexpected_we", g), 1, 0);
                end else begin
                    wr_ev_t e;
                    e = exp_wr[g].pop_front();
                    chk($sformatf("i%0d_we_addr", g), address[g], e.addr);
                    chk($sformatf("i%0d_we_data", g), w_data[g], e.data);
                    chk($sformatf("i%0d_we_cycle", g), cyc, e.cyc);
                end
            end
            if (tx_start[g]) begin
                if (exp_tx[g].size() == 0) begin
                    chk($sformatf("i%0d_unexpected_tx_start", g), 1, 0);
                end else begin
                    tx_ev_t t;
                    int     ec;
                    t  = exp_tx[g].pop_front();
                    ec = (t.cyc >= 0) ? t.cyc : last_done[g] + 1;
                    chk($sformatf("i%0d_tx_byte", g), tx_din[g], t.b);
                    chk($sformatf("i%0d_tx_cycle", g), cyc, ec);
                end
                chk($sformatf("i%0d_tx_start_while_sending", g), tx_busy_m[g], 0);
                tx_busy_m[g] = 1'b1;
                tx_cur[g]    = tx_din[g];
                done_at[g]   = cyc + int'($urandom_range(2, 6));
            end else if (tx_busy_m[g]) begin
                chk($sformatf("i%0d_tx_din_hold", g), tx_din[g], tx_cur[g]);
            end
            if (tx_busy_m[g] || exp_wr[g].size() != 0 || exp_tx[g].size() != 0)
                chk($sformatf("i%0d_busy_high", g), busy[g], 1);
        end

        // Transmitter finishes each byte a few cycles after tx_start
        initial begin
            tx_done_tick[g] = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                tx_done_tick[g] = 1'b0;
                if (tx_busy_m[g] && cyc == done_at[g]) begin
                    tx_done_tick[g] = 1'b1;
                    tx_busy_m[g]    = 1'b0;
                    last_done[g]    = cyc;
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One rx byte in the current cycle; returns one cycle later
    task automatic tick(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        last_t       = cyc;
        wait_cycles(1);
        rx_done_tick = 1'b0;
        rx_data      = 8'($urandom);
    endtask

    // Cycles from one tick to the next; occasionally exactly the timeout boundary
    task automatic gap();
        int g;
        g = ($urandom_range(0, 9) == 0) ? int'(TIMEOUT) : int'($urandom_range(1, 4));
        wait_cycles(g - 1);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d);
        tick(8'h57);
        gap();
        tick(a[15:8]);
        gap();
        tick(a[7:0]);
        for (int k = 0; k < 4; k++) begin
            gap();
            tick(d[31 - 8 * k -: 8]);
        end
        for (int g = 0; g < N_INST; g++) begin
            exp_wr[g].push_back(wr_ev_t'{a, d, last_t + 1});
            exp_tx[g].push_back(tx_ev_t'{ACK, last_t + 2});
        end
        m_addr  = a;
        m_wdata = d;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [31:0] w);
        tick(8'h52);
        gap();
        tick(a[15:8]);
        gap();
        tick(a[7:0]);
        for (int g = 0; g < N_INST; g++) begin
            exp_tx[g].push_back(tx_ev_t'{w[31:24], last_t + 1 + lat_of(g)});
            exp_tx[g].push_back(tx_ev_t'{w[23:16], -1});
            exp_tx[g].push_back(tx_ev_t'{w[15:8], -1});
            exp_tx[g].push_back(tx_ev_t'{w[7:0], -1});
        end
        m_addr = a;
    endtask

    task automatic do_unknown(input logic [7:0] b);
        tick(b);
        for (int g = 0; g < N_INST; g++) exp_tx[g].push_back(tx_ev_t'{NAK, last_t + 1});
    endtask

    function automatic bit all_idle();
        for (int g = 0; g < N_INST; g++)
            if (busy[g] || tx_busy_m[g] || exp_wr[g].size() != 0 || exp_tx[g].size() != 0)
                return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < IDLE_BOUND && !all_idle()) begin
            wait_cycles(1);
            n++;
        end
        chk("idle_within_bound", 64'(n < IDLE_BOUND), 1);
        for (int g = 0; g < N_INST; g++) begin
            chk($sformatf("i%0d_idle_busy", g), busy[g], 0);
            chk($sformatf("i%0d_idle_address", g), address[g], m_addr);
            chk($sformatf("i%0d_idle_w_data", g), w_data[g], m_wdata);
            chk($sformatf("i%0d_pending_events", g), exp_wr[g].size() + exp_tx[g].size(), 0);
            exp_wr[g].delete();
            exp_tx[g].delete();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int g = 0; g < N_INST; g++) begin
            chk($sformatf("i%0d_%s_address", g, tag), address[g], 0);
            chk($sformatf("i%0d_%s_w_data", g, tag), w_data[g], 0);
            chk($sformatf("i%0d_%s_tx_din", g, tag), tx_din[g], 0);
            chk($sformatf("i%0d_%s_we", g, tag), we[g], 0);
            chk($sformatf("i%0d_%s_tx_start", g, tag), tx_start[g], 0);
            chk($sformatf("i%0d_%s_busy", g, tag), busy[g], 0);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int         n;

        rst_n = 1'b0;
        wait_cycles(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        wait_cycles(2);

        // Directed write and read with literal expectations
        do_write(16'h0010, 32'hDEAD_BEEF);
        wait_idle();
        tick(8'h52);
        tick(8'h00);
        tick(8'h20);
        for (int g = 0; g < N_INST; g++) begin
            exp_tx[g].push_back(tx_ev_t'{8'h12, last_t + 1 + lat_of(g)});
            exp_tx[g].push_back(tx_ev_t'{8'h34, -1});
            exp_tx[g].push_back(tx_ev_t'{8'h56, -1});
            exp_tx[g].push_back(tx_ev_t'{8'h78, -1});
        end
        m_addr = 16'h0020;
        wait_idle();

        // Unknown command, then a valid frame is still accepted
        do_unknown(8'hAA);
        wait_idle();
        do_read(16'h0004, bus_word(16'h0004));
        wait_idle();

        // Timeout: 57 00 then silence; busy drops exactly TIMEOUT+1 cycles after the last tick
        tick(8'h57);
        tick(8'h00);
        m_addr = {m_addr[7:0], 8'h00};
        wait_cycles(int'(TIMEOUT) - 1);
        for (int g = 0; g < N_INST; g++) chk($sformatf("i%0d_timeout_edge_busy", g), busy[g], 1);
        wait_cycles(1);
        for (int g = 0; g < N_INST; g++) begin
            chk($sformatf("i%0d_timeout_busy", g), busy[g], 0);
            chk($sformatf("i%0d_timeout_address", g), address[g], m_addr);
        end
        do_read(16'h0004, bus_word(16'h0004));
        wait_idle();

        // A command byte arriving during TX_WAIT must be dropped
        do_write(16'($urandom), $urandom);
        n = 0;
        while (n < 20 && !(tx_busy_m[0] && tx_busy_m[1])) begin
            wait_cycles(1);
            n++;
        end
        chk("drop_reached_tx_wait", 64'(tx_busy_m[0] && tx_busy_m[1]), 1);
        tick(8'h57);
        wait_idle();

        // Reset in the middle of GET_DATA
        tick(8'h57);
        tick(8'h12);
        tick(8'h34);
        tick(8'hAA);
        rst_n = 1'b0;
        wait_cycles(1);
        chk_all_zero("midreset");
        rst_n   = 1'b1;
        m_addr  = 16'h0000;
        m_wdata = 32'h0;
        wait_cycles(20);
        wait_idle();
        do_write(16'hBEEF, 32'h0BAD_F00D);
        wait_idle();

        // Randomized frames
        for (int i = 0; i < 40; i++) begin
            wait_cycles(int'($urandom_range(0, 3)));
            n = int'($urandom_range(0, 9));
            if (n < 4) begin
                do_write(16'($urandom), $urandom);
            end else if (n < 8) begin
                logic [15:0] a;
                a = 16'($urandom);
                do_read(a, bus_word(a));
            end else begin
                do begin
                    b = 8'($urandom);
                end while (b == 8'h57 || b == 8'h52);
                do_unknown(b);
            end
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
